// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between instruction fetch (I) and load/store (D).
// Only one transaction is outstanding at a time. D wins by default. If fetch has been
// passed over MAX_D_STREAK times in a row while requesting, fetch wins the next issue.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   i_req_i/i_addr_i    fetch request and 4-byte aligned byte address
//   i_flush_i           kill the in-flight fetch; its response is discarded
//   i_rvalid_o/i_rdata_o  one-cycle fetch response, 32-bit lane picked by addr bit 2
//   i_stall_o           i_req_i && !i_rvalid_o
//   d_req_i/d_we_i/d_addr_i/d_wdata_i/d_wstrb_i  load/store request and payload
//   d_rvalid_o/d_rdata_o  one-cycle load data / store acknowledge
//   d_stall_o           d_req_i && !d_rvalid_o
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_wstrb_o  memory request side
//   mem_gnt_i           memory accepts the request this cycle
//   mem_rvalid_i/mem_rdata_i  memory response, at least one cycle after accept
module mem_port_arbiter #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req_i,
  input  logic [XLEN-1:0] i_addr_i,
  input  logic            i_flush_i,
  output logic            i_rvalid_o,
  output logic [31:0]     i_rdata_o,
  output logic            i_stall_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [XLEN-1:0] d_addr_i,
  input  logic [XLEN-1:0] d_wdata_i,
  input  logic [7:0]      d_wstrb_i,
  output logic            d_rvalid_o,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            d_stall_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [7:0]      mem_wstrb_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int unsigned StreakW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [2:0] {StIdle, StReqI, StReqD, StWaitI, StWaitD} state_e;

  state_e             state_q, state_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic               drop_q, drop_d;
  logic               addr2_q, addr2_d;
  logic [XLEN-1:0]    i_addr_q, i_addr_d;

  logic            streak_max;
  logic            pick_d, pick_i;
  logic            sel_i, sel_d;
  logic            i_acc, d_acc;
  logic [XLEN-1:0] fetch_addr;

  assign streak_max = (streak_q == StreakW'(MAX_D_STREAK));

  // Arbitration decision, only meaningful in StIdle.
  assign pick_d = d_req_i && !(i_req_i && streak_max);
  assign pick_i = !pick_d && i_req_i;

  // Which requester currently owns the memory request.
  assign sel_i = ((state_q == StIdle) && pick_i) || (state_q == StReqI);
  assign sel_d = ((state_q == StIdle) && pick_d) || (state_q == StReqD);

  // A flushed fetch stuck in StReqI must keep presenting its original address even if the
  // fetch unit has already dropped i_req_i and moved i_addr_i on.
  assign fetch_addr = (state_q == StReqI) ? i_addr_q : i_addr_i;

  assign i_acc = sel_i && mem_gnt_i;
  assign d_acc = sel_d && mem_gnt_i;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pick_d) begin
          state_d = mem_gnt_i ? StWaitD : StReqD;
        end else if (pick_i) begin
          state_d = mem_gnt_i ? StWaitI : StReqI;
        end
      end
      StReqI:  if (mem_gnt_i) state_d = StWaitI;
      StReqD:  if (mem_gnt_i) state_d = StWaitD;
      StWaitI: if (mem_rvalid_i) state_d = StIdle;
      StWaitD: if (mem_rvalid_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    if (sel_i) begin
      mem_req_o  = 1'b1;
      mem_addr_o = fetch_addr;
    end else if (sel_d) begin
      mem_req_o   = 1'b1;
      mem_we_o    = d_we_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
      mem_wstrb_o = d_wstrb_i;
    end
    // A flush in the response cycle itself suppresses the pulse as well.
    i_rvalid_o = (state_q == StWaitI) && mem_rvalid_i && !drop_q && !i_flush_i;
    d_rvalid_o = (state_q == StWaitD) && mem_rvalid_i;
    i_rdata_o  = addr2_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
    d_rdata_o  = mem_rdata_i;
    i_stall_o  = i_req_i && !i_rvalid_o;
    d_stall_o  = d_req_i && !d_rvalid_o;
  end

  // Streak counter, fetch lane select, drop flag, held fetch address
  always_comb begin
    streak_d = streak_q;
    if (i_acc) begin
      streak_d = '0;
    end else if (d_acc && i_req_i && !streak_max) begin
      streak_d = streak_q + StreakW'(1);
    end

    addr2_d = i_acc ? fetch_addr[2] : addr2_q;

    i_addr_d = (state_q == StIdle) ? i_addr_i : i_addr_q;

    drop_d = drop_q;
    if (i_flush_i && ((state_q == StReqI) || (state_q == StWaitI))) begin
      drop_d = 1'b1;
    end
    if (state_d == StIdle) begin
      drop_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
      addr2_q  <= 1'b0;
      i_addr_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      streak_q <= streak_d;
      addr2_q  <= addr2_d;
      i_addr_q <= i_addr_d;
      drop_q   <= drop_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a driver issues requests and pushes expected
// responses; a negedge monitor checks arbitration and pops expectations on each rvalid.
module tb_mem_port_arbiter;

  localparam int unsigned XLEN = 64;
  localparam int          MAXS = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_req = 1'b0, i_flush = 1'b0, i_rvalid, i_stall;
  logic [XLEN-1:0] i_addr = '0;
  logic [31:0]     i_rdata;
  logic            d_req = 1'b0, d_we = 1'b0, d_rvalid, d_stall;
  logic [XLEN-1:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic [7:0]      d_wstrb = '0;
  logic            mem_req, mem_we;
  logic [XLEN-1:0] mem_addr, mem_wdata;
  logic [7:0]      mem_wstrb;
  logic            mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_flush_i(i_flush),
    .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata), .i_stall_o(i_stall),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_wstrb_i(d_wstrb), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata), .d_stall_o(d_stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  typedef struct {
    logic        chk;
    logic [63:0] data;
  } exp_t;

  exp_t i_q[$];
  exp_t d_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model controls
  logic gnt_rand = 1'b0;
  int   lat_fix  = 1;
  logic stray_en = 1'b0;

  // Monitor -> driver / memory model events
  int unsigned     acc_cnt = 0;
  logic [63:0]     acc_addr = '0;
  logic            acc_we = 1'b0;
  int unsigned     i_rv_cnt = 0, d_rv_cnt = 0;
  logic            i_infl = 1'b0, i_pres = 1'b0;
  int              streak = 0;
  // Driver -> monitor: number of fetches killed by flush
  int unsigned     i_kill_cnt = 0;

  // Driver-private bookkeeping
  int unsigned i_rv_seen = 0, d_rv_seen = 0;
  logic        gen_en = 1'b0;

  // Memory contents: a fixed function of the 8-byte-aligned address.
  function automatic logic [63:0] pat(input logic [63:0] a);
    logic [63:0] a8;
    a8 = a & ~64'h7;
    return {a8[31:0] ^ 32'hAAAA_BBBB, a8[31:0] ^ 32'hCCCC_DDDD};
  endfunction

  function automatic logic [31:0] lane(input logic [63:0] a);
    logic [63:0] p;
    p = pat(a);
    return a[2] ? p[63:32] : p[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Memory: one outstanding access, latency lat cycles after the cycle following accept.
  initial begin : mem_model
    int          lat;
    logic        busy;
    logic [63:0] resp;
    int unsigned acc_seen;
    busy = 1'b0; lat = 0; resp = '0; acc_seen = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      if (busy) begin
        lat--;
        if (lat == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = resp;
          busy       = 1'b0;
        end
      end else if (acc_seen == acc_cnt && stray_en && $urandom_range(0, 7) == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = {$urandom, $urandom};
      end
      if (acc_seen != acc_cnt) begin
        acc_seen = acc_cnt;
        busy     = 1'b1;
        lat      = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
        resp     = acc_we ? {$urandom, $urandom} : pat(acc_addr);
      end
      mem_gnt = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: arbitration reference model on the memory side, scoreboard on responses.
  initial begin : monitor
    int unsigned  kill_seen;
    logic         prev_req;
    logic [136:0] lock_p, cur_p;
    logic         exp_d, is_f;
    exp_t         e;
    kill_seen = 0; prev_req = 1'b0; lock_p = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
        streak   = 0;
        i_infl   = 1'b0;
        i_pres   = 1'b0;
      end else begin
        cur_p = {mem_we, mem_wstrb, mem_addr, mem_wdata};
        if (mem_rvalid) i_infl = 1'b0;
        if (mem_req) begin
          is_f = (mem_addr[15:12] == 4'h1);
          if (!prev_req) begin
            // New issue: D wins unless fetch is waiting and D has used up its streak.
            exp_d = d_req && !(i_req && streak == MAXS);
            check("issue_has_requester", {63'b0, i_req | d_req}, 64'd1);
            check("winner_is_fetch", {63'b0, is_f}, {63'b0, !exp_d});
            if (!exp_d) begin
              check("fetch_addr", mem_addr, i_addr);
              check("fetch_we_wstrb", {55'b0, mem_we, mem_wstrb}, 64'd0);
            end else begin
              check("d_addr", mem_addr, d_addr);
              check("d_wdata", mem_wdata, d_wdata);
              check("d_we_wstrb", {55'b0, mem_we, mem_wstrb}, {55'b0, d_we, d_wstrb});
            end
            lock_p = cur_p;
          end else begin
            n_tests++;
            if (cur_p !== lock_p) begin
              n_fail++;
              $display("FAIL locked_payload: got %h, required %h", cur_p, lock_p);
            end
          end
          if (mem_gnt) begin
            acc_addr = mem_addr;
            acc_we   = mem_we;
            acc_cnt++;
            i_pres   = 1'b0;
            if (is_f) begin
              i_infl = 1'b1;
              streak = 0;
            end else if (i_req && streak < MAXS) begin
              streak++;
            end
          end else begin
            i_pres = is_f;
          end
        end else begin
          i_pres = 1'b0;
        end
        prev_req = mem_req;

        while (kill_seen != i_kill_cnt) begin
          if (i_q.size() > 0) void'(i_q.pop_back());
          kill_seen++;
        end
        if (i_rvalid) begin
          i_rv_cnt++;
          if (i_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL i_rvalid_unexpected: got i_rvalid=1, required 0 (nothing pending)");
          end else begin
            e = i_q.pop_front();
            check("i_rdata", {32'h0, i_rdata}, e.data);
          end
        end
        if (d_rvalid) begin
          d_rv_cnt++;
          if (d_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL d_rvalid_unexpected: got d_rvalid=1, required 0 (nothing pending)");
          end else begin
            e = d_q.pop_front();
            if (e.chk) check("d_rdata", d_rdata, e.data);
          end
        end
        check("i_stall", {63'b0, i_stall}, {63'b0, i_req && !i_rvalid});
        check("d_stall", {63'b0, d_stall}, {63'b0, d_req && !d_rvalid});
      end
    end
  end

  task automatic new_fetch();
    i_req  = 1'b1;
    i_addr = 64'h1000 + 64'({$urandom_range(0, 1023), 2'b00});
    i_q.push_back('{1'b1, {32'h0, lane(i_addr)}});
  endtask

  task automatic new_data();
    d_req  = 1'b1;
    d_we   = 1'($urandom_range(0, 1));
    d_addr = 64'h8000 + 64'({$urandom_range(0, 511), 3'b000});
    if (d_we) begin
      d_wdata = {$urandom, $urandom};
      d_wstrb = 8'($urandom_range(1, 255));
    end else begin
      d_wdata = '0;
      d_wstrb = '0;
    end
    d_q.push_back('{!d_we, pat(d_addr)});
  endtask

  // One cycle of requester behaviour, applied just after the rising edge.
  task automatic rand_step();
    i_flush = 1'b0;
    if (i_req && i_rv_seen != i_rv_cnt) begin
      i_rv_seen = i_rv_cnt;
      if (gen_en && $urandom_range(0, 1) == 1) new_fetch();
      else i_req = 1'b0;
    end else if (i_req && gen_en && $urandom_range(0, 9) == 0) begin
      i_flush = 1'b1;
      i_req   = 1'b0;
      i_kill_cnt++;
    end else if (!i_req && gen_en && !(i_infl || i_pres) && $urandom_range(0, 2) == 0) begin
      new_fetch();
    end
    if (d_req && d_rv_seen != d_rv_cnt) begin
      d_rv_seen = d_rv_cnt;
      if (gen_en && $urandom_range(0, 3) != 0) new_data();
      else d_req = 1'b0;
    end else if (!d_req && gen_en && $urandom_range(0, 1) == 0) begin
      new_data();
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_req", {63'b0, mem_req}, 64'd0);
    check("rst_i_rvalid", {63'b0, i_rvalid}, 64'd0);
    check("rst_d_rvalid", {63'b0, d_rvalid}, 64'd0);
    check("rst_stalls", {62'b0, i_stall, d_stall}, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Fetch only, always granted, 1-cycle memory latency
    #1;
    i_req  = 1'b1;
    i_addr = 64'h1004;
    i_q.push_back('{1'b1, {32'h0, lane(64'h1004)}});
    @(negedge clk);
    check("f0_mem_req", {63'b0, mem_req}, 64'd1);
    check("f0_i_stall", {63'b0, i_stall}, 64'd1);
    @(negedge clk);
    check("f1_mem_req", {63'b0, mem_req}, 64'd0);
    check("f1_i_stall", {63'b0, i_stall}, 64'd1);
    @(negedge clk);
    check("f2_i_rvalid", {63'b0, i_rvalid}, 64'd1);
    check("f2_i_rdata", {32'h0, i_rdata}, 64'h0000_0000_AAAA_ABBB);
    check("f2_i_stall", {63'b0, i_stall}, 64'd0);
    @(posedge clk); #1; i_req = 1'b0;
    repeat (2) @(posedge clk);

    // Reset while a load is in WAIT_D; its late response must be ignored
    lat_fix = 3;
    #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h8010; d_wdata = '0; d_wstrb = '0;
    @(negedge clk);
    check("r0_mem_req", {63'b0, mem_req}, 64'd1);
    @(posedge clk); #1; rst_n = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("r1_mem_req", {63'b0, mem_req}, 64'd0);
    check("r1_d_rvalid", {63'b0, d_rvalid}, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rpost_d_rvalid", {63'b0, d_rvalid}, 64'd0);
      check("rpost_mem_req", {63'b0, mem_req}, 64'd0);
    end
    repeat (2) @(posedge clk);

    // Randomized traffic: random grants, latencies, stray responses, flushes
    i_rv_seen = i_rv_cnt;
    d_rv_seen = d_rv_cnt;
    gnt_rand  = 1'b1;
    lat_fix   = 0;
    stray_en  = 1'b1;
    gen_en    = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      rand_step();
    end

    // Drain outstanding work without issuing new requests
    gen_en = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      rand_step();
      if (!i_req && !d_req && i_q.size() == 0 && d_q.size() == 0) break;
    end
    i_flush = 1'b0;
    repeat (2) @(negedge clk);
    check("drain_i_q_empty", 64'(i_q.size()), 64'd0);
    check("drain_d_q_empty", 64'(d_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
